uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx transmitter between NUM_REQ byte sources (status reporter, command echo, debug dump).
- Round-robin arbitration per byte, with optional packet lock so that a multi-byte message from one source is never interleaved.
- Sequences uart_tx: presents data_in, pulses en for one cycle, and tracks rdy until the byte completes.
- Sits in top between the requesting blocks and uart_tx, which drives board1_rx / ftdi lines.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PKT_LOCK, 1, 1 = hold the grant from a byte with req_last=0 until that owner's byte with req_last=1; 0 = arbitrate every byte.
- LOCK_TIMEOUT, 1000000, cycles a locked owner may leave req_valid low before the lock is forcibly released.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the last of its packet
- req_ready  out  NUM_REQ  byte accepted; transfer occurs when valid&ready
- tx_data  out  8  to uart_tx data_in
- tx_en  out  1  to uart_tx en; one-cycle pulse
- tx_rdy  in  1  from uart_tx rdy; high = idle
- grant  out  NUM_REQ  one-hot owner of the current or locked transfer; 0 when none
- locked  out  1  packet lock active
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; tx_en=0; tx_data=8'h00; grant=0; locked=0; RR pointer=0; timeout counter=0. req_ready is combinational, so it is 0 while state!=IDLE.
- States: IDLE -> ISSUE -> GUARD -> WAIT -> IDLE.
- IDLE, selection:
  - Eligible set = all requesters with req_valid=1. If locked, the eligible set is the owner only.
  - Selection is round-robin: the first eligible index at or above the pointer, wrapping modulo NUM_REQ.
  - When tx_rdy=1 and the set is non-empty, req_ready[sel]=1 combinationally in the same cycle. All other req_ready bits stay 0.
- IDLE, acceptance (at the accepting edge):
  - tx_data <= req_data[sel]; grant <= onehot(sel); state <= ISSUE.
  - If PKT_LOCK=1 and req_last[sel]=0: locked <= 1. Otherwise locked <= 0 and pointer <= sel+1 mod NUM_REQ.
  - If tx_rdy=0, IDLE waits with no req_ready asserted.
- ISSUE: tx_en=1 for exactly this cycle; tx_data is held stable. Next state is GUARD.
- GUARD: one cycle in which tx_rdy is ignored, because uart_tx drops rdy up to one cycle after en. Next state is WAIT.
- WAIT: stay until tx_rdy=1, then go to IDLE. tx_data is held until leaving WAIT.
- grant: cleared on return to IDLE unless locked=1, in which case the owner's bit is held.
- Throughput: minimum 3 cycles plus the uart_tx frame time per byte. Valid-to-tx_en latency is 1 cycle when idle.
- Lock timeout:
  - While locked and in IDLE with req_valid[owner]=0, the counter increments each cycle.
  - When it reaches LOCK_TIMEOUT-1: locked <= 0, grant <= 0, pointer <= owner+1, counter <= 0.
  - Any acceptance also clears the counter.
- Simultaneous events:
  - Multiple valids: only one is accepted per IDLE visit.
  - A non-owner asserting valid while locked is ignored and held off (ready=0).
- Requester contract: a requester holds req_valid, req_data and req_last stable until accepted. The arbiter never drops an accepted byte.
- Reset mid-operation: any in-flight uart_tx frame completes on its own. After reset the arbiter waits in IDLE for tx_rdy=1 before accepting.

Test Plan:
- Single request: req_valid[0]=1, data 8'h3A, tx_rdy=1 -> req_ready[0] high in the same cycle, tx_en pulses 1 cycle later with tx_data=8'h3A, busy until tx_rdy returns high.
- Contention: valid[0..3] all high with last=1 and PKT_LOCK=0 -> bytes are sent in order 0,1,2,3,0; no tx_en pulse while tx_rdy=0.
- Packet lock: req1 sends 8'h69,8'h6A,8'h6B with last only on the third byte while req0 is valid throughout -> all three req1 bytes go out consecutively, then req0.
- Lock timeout (LOCK_TIMEOUT=16): req2 sends one byte with last=0 then drops valid -> locked=1 for 16 idle cycles, then locked=0 and the pending req3 byte is served.
- GUARD check: uart model keeps rdy high for 1 cycle after en -> no second en is issued; exactly one byte per acceptance.
- Reset mid-WAIT: rst_n=0 for 2 cycles -> tx_en=0, grant=0, locked=0 immediately; no req_ready until tx_rdy=1 after release.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter in front of a single uart_tx transmitter, with an
// optional per-packet grant lock that is released by a timeout if the owner stalls.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PKT_LOCK     = 1,
  parameter int LOCK_TIMEOUT = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_en,
  input  logic                   tx_rdy,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   locked,
  output logic                   busy
);

  localparam int DATA_W = 8;
  localparam int IW     = $clog2(NUM_REQ);
  localparam int CW     = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] GUARD = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [1:0]         state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] eligible;
  logic [IW:0]        pick;
  logic [IW-1:0]      sel;
  logic               sel_any;
  logic               accept;
  logic               owner_stall;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
  endfunction

  // Scan from the highest offset down so the nearest eligible index at or
  // above base is the one left in res; bit IW flags that something was found.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                          input logic [IW-1:0]      base);
    logic [IW:0] res;
    logic [IW:0] sum;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, base} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      if (elig[sum[IW-1:0]]) res = {1'b1, sum[IW-1:0]};
    end
    return res;
  endfunction

  assign eligible    = locked ? (req_valid & grant) : req_valid;
  assign pick        = rr_pick(eligible, ptr);
  assign sel_any     = pick[IW];
  assign sel         = pick[IW-1:0];
  assign accept      = (state == IDLE) && tx_rdy && sel_any;
  assign owner_stall = locked && (state == IDLE) && !req_valid[owner];

  assign req_ready = accept ? onehot(sel) : '0;
  assign tx_en     = (state == ISSUE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_data <= '0;
      grant   <= '0;
      locked  <= 1'b0;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data <= req_data[{sel, 3'b000} +: DATA_W];
            grant   <= onehot(sel);
            owner   <= sel;
            cnt     <= '0;
            state   <= ISSUE;
            if (PKT_LOCK != 0 && !req_last[sel]) begin
              locked <= 1'b1;
            end else begin
              locked <= 1'b0;
              ptr    <= next_idx(sel);
            end
          end else if (owner_stall) begin
            // Owner went quiet mid-packet: give everyone else a turn.
            if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
              locked <= 1'b0;
              grant  <= '0;
              ptr    <= next_idx(owner);
              cnt    <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ISSUE: state <= GUARD;
        // uart_tx may still show rdy=1 here, so this cycle never samples it.
        GUARD: state <= WAIT;
        WAIT: begin
          if (tx_rdy) begin
            state <= IDLE;
            if (!locked) grant <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic
// compared against a queue-based round-robin/lock reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_en;
  logic           tx_rdy = 1'b1;
  logic [N-1:0]   grant;
  logic           locked;
  logic           busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .PKT_LOCK(1), .LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_en(tx_en),
    .tx_rdy(tx_rdy), .grant(grant), .locked(locked), .busy(busy)
  );

  typedef struct packed { logic [7:0] d; logic l; } byte_t;
  typedef struct packed { logic [7:0] d; logic [N-1:0] g; logic l; } sent_t;

  byte_t rq [N][$];
  byte_t mq [N][$];
  sent_t sent_q[$];
  sent_t exp_q[$];

  int checks = 0;
  int errors = 0;
  logic [N-1:0] acc = '0;
  bit en_prev = 1'b0;
  int n_en, n_acc, overrun, busy_gap;
  bit uart_auto = 1'b1, rdy_manual = 1'b1, uart_lag = 1'b0, lag_rand = 1'b0, lag_pend = 1'b0;
  bit mon_en = 1'b1;
  int frame_len = 3, frame_left = 0;

  function automatic byte_t mk(input logic [7:0] d, input logic l);
    byte_t b;
    b.d = d;
    b.l = l;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = rq[i][0].d;
        req_last[i]       = rq[i][0].l;
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  // One clock: inputs change just after the rising edge, outputs are sampled
  // on the falling edge. The uart model and requesters react to what was
  // sampled on the previous falling edge.
  task automatic tick();
    byte_t dummy;
    sent_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && rq[i].size() > 0) dummy = rq[i].pop_front();
    if (uart_auto) begin
      if (lag_pend) begin
        lag_pend = 1'b0; tx_rdy = 1'b0; frame_left = frame_len;
      end else if (frame_left > 0) begin
        frame_left--;
        if (frame_left == 0) tx_rdy = 1'b1;
      end
      if (en_prev) begin
        if (lag_rand) begin
          uart_lag  = ($urandom_range(0, 1) == 1);
          frame_len = $urandom_range(1, 4);
        end
        if (uart_lag) lag_pend = 1'b1;
        else begin tx_rdy = 1'b0; frame_left = frame_len; end
      end
    end else begin
      tx_rdy = rdy_manual;
    end
    drive_reqs();
    @(negedge clk);
    acc     = req_valid & req_ready;
    en_prev = tx_en;
    if (tx_en) begin
      e.d = tx_data; e.g = grant; e.l = locked;
      sent_q.push_back(e);
      n_en++;
      if (!tx_rdy || lag_pend || frame_left != 0) overrun++;
    end
    if (acc != '0) n_acc++;
    if (mon_en && uart_auto && !tx_rdy && !busy) busy_gap++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    drive_reqs();
    uart_auto = 1'b1; tx_rdy = 1'b1; lag_pend = 1'b0; frame_left = 0;
    frame_len = 3; uart_lag = 1'b0; lag_rand = 1'b0; mon_en = 1'b1;
    sent_q.delete();
    n_en = 0; n_acc = 0; overrun = 0; busy_gap = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    acc     = req_valid & req_ready;
    en_prev = tx_en;
  endtask

  task automatic wait_sent(input int n, input int limit, input string tag);
    int t;
    t = 0;
    while (sent_q.size() < n && t < limit) begin tick(); t++; end
    chk(tag, sent_q.size(), n);
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int t;
    t = 0;
    while (busy && t < limit) begin tick(); t++; end
    chk(tag, busy, 0);
  endtask

  // Reference: round-robin over non-empty requester queues, sticking to one
  // requester while its packet is unfinished.
  task automatic build_expect(output int total);
    int ptr_m, own, s, c;
    bit lk;
    byte_t b;
    sent_t e;
    exp_q.delete();
    total = 0;
    for (int i = 0; i < N; i++) begin mq[i] = rq[i]; total += mq[i].size(); end
    ptr_m = 0; lk = 1'b0; own = 0;
    for (int k = 0; k < total; k++) begin
      if (lk) s = own;
      else begin
        s = -1;
        for (int j = 0; j < N; j++) begin
          c = (ptr_m + j) % N;
          if (s < 0 && mq[c].size() > 0) s = c;
        end
      end
      b = mq[s].pop_front();
      lk = !b.l; own = s;
      if (b.l) ptr_m = (s + 1) % N;
      e.d = b.d; e.g = '0; e.g[s] = 1'b1; e.l = !b.l;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, t, lk_cycles, total, np, len;
    logic [N-1:0] eg;

    do_reset();
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_grant", grant, 0);
    chk("rst_locked", locked, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);

    // Single request
    rq[0].push_back(mk(8'h3A, 1'b1));
    tick();
    chk("t1_ready_same_cycle", req_ready, 4'b0001);
    chk("t1_no_en_yet", tx_en, 0);
    tick();
    chk("t1_en", tx_en, 1);
    chk("t1_data", tx_data, 8'h3A);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_en_one_cycle", tx_en, 0);
    wait_idle(40, "t1_idle");
    chk("t1_grant_clear", grant, 0);
    chk("t1_single_en", n_en, 1);
    chk("t1_busy_tracks_rdy", busy_gap, 0);

    // Contention, with the transmitter held busy at first
    do_reset();
    uart_auto = 1'b0; rdy_manual = 1'b0;
    for (int i = 0; i < N; i++) rq[i].push_back(mk(8'(8'h10 + i), 1'b1));
    rq[0].push_back(mk(8'h14, 1'b1));
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (tx_en || req_ready != '0) bad++;
    end
    chk("t2_hold_while_rdy_low", bad, 0);
    rdy_manual = 1'b1;
    tick();
    uart_auto = 1'b1;
    wait_sent(5, 300, "t2_count");
    wait_idle(40, "t2_idle");
    for (int k = 0; k < 5 && k < sent_q.size(); k++) begin
      eg = 4'b0001 << (k % 4);
      chk($sformatf("t2_data%0d", k), sent_q[k].d, 8'h10 + k);
      chk($sformatf("t2_grant%0d", k), sent_q[k].g, eg);
    end
    chk("t2_en_per_accept", n_en, n_acc);

    // Packet lock: req1's three bytes go out back to back ahead of req0
    do_reset();
    rq[1].push_back(mk(8'h69, 1'b0));
    rq[1].push_back(mk(8'h6A, 1'b0));
    rq[1].push_back(mk(8'h6B, 1'b1));
    tick();
    rq[0].push_back(mk(8'h55, 1'b1));
    wait_sent(4, 400, "t3_count");
    if (sent_q.size() >= 4) begin
      chk("t3_b0", {sent_q[0].d, sent_q[0].g, 3'b000, sent_q[0].l}, {8'h69, 4'b0010, 4'b0001});
      chk("t3_b1", {sent_q[1].d, sent_q[1].g, 3'b000, sent_q[1].l}, {8'h6A, 4'b0010, 4'b0001});
      chk("t3_b2", {sent_q[2].d, sent_q[2].g, 3'b000, sent_q[2].l}, {8'h6B, 4'b0010, 4'b0000});
      chk("t3_b3", {sent_q[3].d, sent_q[3].g, 3'b000, sent_q[3].l}, {8'h55, 4'b0001, 4'b0000});
    end

    // Lock timeout: req2 stalls mid-packet, req3 waits
    do_reset();
    rq[2].push_back(mk(8'hC2, 1'b0));
    tick();
    rq[3].push_back(mk(8'hD3, 1'b1));
    wait_sent(1, 100, "t4_first");
    chk("t4_first_locked", locked, 1);
    lk_cycles = 0; bad = 0; t = 0;
    while (locked && t < 200) begin
      tick(); t++;
      if (!busy && locked) begin
        lk_cycles++;
        if (req_ready != '0) bad++;
      end
    end
    chk("t4_locked_idle_cycles", lk_cycles, TMO);
    chk("t4_held_off", bad, 0);
    chk("t4_grant_released", grant, 0);
    chk("t4_req3_ready", req_ready, 4'b1000);
    wait_sent(2, 100, "t4_second");
    if (sent_q.size() >= 2) chk("t4_req3_byte", {sent_q[1].d, sent_q[1].g}, {8'hD3, 4'b1000});

    // Transmitter whose rdy lags en by a cycle
    do_reset();
    uart_lag = 1'b1; frame_len = 2;
    rq[0].push_back(mk(8'hA1, 1'b1));
    rq[0].push_back(mk(8'hA2, 1'b1));
    rq[2].push_back(mk(8'hA3, 1'b1));
    wait_sent(3, 200, "t5_count");
    wait_idle(40, "t5_idle");
    repeat (8) tick();
    chk("t5_en_count", n_en, 3);
    chk("t5_acc_count", n_acc, 3);
    chk("t5_overrun", overrun, 0);
    chk("t5_busy_tracks_rdy", busy_gap, 0);
    if (sent_q.size() >= 3)
      chk("t5_order", {sent_q[0].d, sent_q[1].d, sent_q[2].d}, {8'hA1, 8'hA3, 8'hA2});

    // Reset while waiting on a frame
    do_reset();
    frame_len = 12;
    rq[1].push_back(mk(8'h77, 1'b0));
    wait_sent(1, 50, "t6_first");
    t = 0;
    while (!(busy && !tx_rdy) && t < 50) begin tick(); t++; end
    chk("t6_reached_wait", busy && !tx_rdy, 1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en", tx_en, 0);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_busy", busy, 0);
    rq[0].push_back(mk(8'h88, 1'b1));
    bad = 0;
    repeat (2) begin tick(); if (req_ready != '0) bad++; end
    rst_n = 1'b1;
    t = 0;
    while (!tx_rdy && t < 60) begin
      if (req_ready != '0) bad++;
      tick(); t++;
    end
    chk("t6_no_ready_before_rdy", bad, 0);
    chk("t6_rdy_back", tx_rdy, 1);
    chk("t6_ready_after", req_ready, 4'b0001);
    mon_en = 1'b1;
    wait_sent(2, 100, "t6_second");
    if (sent_q.size() >= 2) chk("t6_byte", {sent_q[1].d, sent_q[1].g}, {8'h88, 4'b0001});

    // Randomized packet traffic
    for (int r = 0; r < 3; r++) begin
      do_reset();
      lag_rand = 1'b1; frame_len = 2;
      for (int i = 0; i < N; i++) begin
        np = $urandom_range(1, 3);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) rq[i].push_back(mk(8'($urandom), b == len - 1));
        end
      end
      build_expect(total);
      wait_sent(total, 3000, "rnd_count");
      wait_idle(40, "rnd_idle");
      repeat (8) tick();
      chk("rnd_en_count", n_en, total);
      chk("rnd_acc_count", n_acc, total);
      chk("rnd_overrun", overrun, 0);
      chk("rnd_busy_tracks_rdy", busy_gap, 0);
      for (int k = 0; k < total && k < sent_q.size(); k++)
        chk($sformatf("rnd%0d_byte%0d", r, k), {sent_q[k].d, sent_q[k].g, sent_q[k].l},
            {exp_q[k].d, exp_q[k].g, exp_q[k].l});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
